// File: rtl/ex_mem_skid.sv
// Two-entry skid buffer between EX and MEM; registers every MEM-facing field
// so out_ready never reaches EX combinationally, and holds the GT/ET flags.
module ex_mem_skid #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_gt,
  input  logic              in_et,
  input  logic [DATA_W-1:0] in_op2,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_is_ld,
  input  logic              in_is_st,
  input  logic              in_is_wb,
  input  logic              in_is_cmp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_op2,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_is_ld,
  output logic              out_is_st,
  output logic              out_is_wb,
  output logic              flags_gt,
  output logic              flags_et,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] op2;
    logic [RD_W-1:0]   rd;
    logic              is_ld;
    logic              is_st;
    logic              is_wb;
  } entry_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t head;
  entry_t skid;
  entry_t in_entry;
  logic   push;
  logic   pop;

  assign in_entry = '{result: in_result, op2: in_op2, rd: in_rd,
                      is_ld: in_is_ld, is_st: in_is_st, is_wb: in_is_wb};

  // Ready is a function of state only, never of out_ready.
  assign in_ready = !rst && (state != S_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      head      <= '0;
      skid      <= '0;
      flags_gt  <= 1'b0;
      flags_et  <= 1'b0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
    end else begin
      if (push && in_is_cmp) begin
        flags_gt <= in_gt;
        flags_et <= in_et;
      end
      case (state)
        S_EMPTY: begin
          if (push) begin
            head      <= in_entry;
            state     <= S_ONE;
            out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (push && pop) begin
            head <= in_entry;
          end else if (push) begin
            skid  <= in_entry;
            state <= S_FULL;
          end else if (pop) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (pop) begin
            head  <= skid;
            state <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign count      = state;
  assign out_result = head.result;
  assign out_op2    = head.op2;
  assign out_rd     = head.rd;
  assign out_is_ld  = head.is_ld;
  assign out_is_st  = head.is_st;
  assign out_is_wb  = head.is_wb;

endmodule
